// File: rtl/simt_alu_pipe.sv
// rtl/simt_alu_pipe.sv - pipelined multi-lane SIMT integer ALU with valid/ready backpressure

package simt_alu_pkg;

  // Supported ALU operations; the remaining 4-bit codes are illegal.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MIN  = 4'd10,
    ALU_MAX  = 4'd11,
    ALU_MINU = 4'd12,
    ALU_MAXU = 4'd13
  } alu_op_t;

endpackage

module simt_alu_pipe
  import simt_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_LANES  = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  alu_op_t                   in_op,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [NUM_LANES*XLEN-1:0] in_a,
  input  logic [NUM_LANES*XLEN-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES-1:0]      out_mask,
  output logic [TAG_W-1:0]          out_tag,
  output logic [NUM_LANES*XLEN-1:0] out_result,
  output logic                      out_illegal
);

  localparam int SH_W = $clog2(XLEN);
  localparam int DW   = NUM_LANES * XLEN;
  localparam int LAST = PIPE_DEPTH - 1;

  // Marker value written into every active lane of an unsupported op.
  localparam logic [XLEN-1:0] ILLEGAL_LANE = XLEN'(32'h000E2202);

  // Everything that travels with a beat through the pipe.
  typedef struct packed {
    logic                 illegal;
    logic [TAG_W-1:0]     tag;
    logic [NUM_LANES-1:0] mask;
    logic [DW-1:0]        result;
  } beat_t;

  beat_t                calc_beat;
  beat_t                stage_beat [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic [PIPE_DEPTH-1:0] stage_adv;

  function automatic logic op_is_legal(input alu_op_t op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

  // One lane of the ALU. Min/max pick b only on a strict comparison so ties return a.
  function automatic logic [XLEN-1:0] lane_compute(
    input alu_op_t         op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SH_W-1:0] sh;
    logic            a_lt_b_s;
    logic            b_lt_a_s;
    logic            a_lt_b_u;
    logic            b_lt_a_u;
    logic [XLEN-1:0] r;
    sh       = b[SH_W-1:0];
    a_lt_b_s = $signed(a) < $signed(b);
    b_lt_a_s = $signed(b) < $signed(a);
    a_lt_b_u = a < b;
    b_lt_a_u = b < a;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $unsigned($signed(a) >>> sh);
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, a_lt_b_s};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, a_lt_b_u};
      ALU_MIN:  r = b_lt_a_s ? b : a;
      ALU_MAX:  r = a_lt_b_s ? b : a;
      ALU_MINU: r = b_lt_a_u ? b : a;
      ALU_MAXU: r = a_lt_b_u ? b : a;
      default:  r = ILLEGAL_LANE;
    endcase
    return r;
  endfunction

  // Compute the whole beat ahead of stage 0; inactive lanes are forced to zero.
  always_comb begin
    calc_beat         = '0;
    calc_beat.illegal = ~op_is_legal(in_op);
    calc_beat.tag     = in_tag;
    calc_beat.mask    = in_mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      calc_beat.result[i*XLEN +: XLEN] =
        in_mask[i] ? lane_compute(in_op, in_a[i*XLEN +: XLEN], in_b[i*XLEN +: XLEN])
                   : '0;
    end
  end

  // A stage moves when the consumer takes a beat or any stage at or beyond it is empty,
  // which is the unrolled form of "empty or next stage advances" and lets bubbles collapse.
  always_comb begin
    logic full_tail;
    stage_adv = '0;
    full_tail = 1'b1;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        full_tail = full_tail & stage_valid[j];
      end
      stage_adv[k] = out_ready | ~full_tail;
    end
  end

  // Pipe registers: valid bits always shift on advance, payload only loads behind a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        stage_beat[k] <= '0;
      end
    end else begin
      if (stage_adv[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_beat[0] <= calc_beat;
        end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (stage_adv[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_beat[k] <= stage_beat[k-1];
          end
        end
      end
    end
  end

  assign in_ready    = stage_adv[0];
  assign out_valid   = stage_valid[LAST];
  assign out_mask    = stage_beat[LAST].mask;
  assign out_tag     = stage_beat[LAST].tag;
  assign out_result  = stage_beat[LAST].result;
  assign out_illegal = stage_beat[LAST].illegal;

endmodule

// File: tb/tb_simt_alu_pipe.sv
// tb/tb_simt_alu_pipe.sv - self-checking bench for simt_alu_pipe with a queue-based reference model

module tb_simt_alu_pipe;
  import simt_alu_pkg::*;

  localparam int XLEN = 32;
  localparam int NL   = 4;
  localparam int PD   = 2;
  localparam int TW   = 4;
  localparam int DW   = NL * XLEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  alu_op_t       in_op;
  logic [NL-1:0] in_mask;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [NL-1:0] out_mask;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_result;
  logic          out_illegal;

  always #5 clk = ~clk;

  simt_alu_pipe #(
    .XLEN(XLEN), .NUM_LANES(NL), .PIPE_DEPTH(PD), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mask(in_mask),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_tag(out_tag), .out_result(out_result), .out_illegal(out_illegal)
  );

  int checks = 0;
  int errors = 0;
  int outs_seen = 0;

  typedef struct {
    logic [DW-1:0] result;
    logic [NL-1:0] mask;
    logic [TW-1:0] tag;
    logic          illegal;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [DW-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference lane: signed order via offset-binary, arithmetic shift via explicit sign fill.
  function automatic logic [31:0] ref_lane(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] sa;
    logic [31:0] sb;
    sh = b[4:0];
    sa = a ^ 32'h8000_0000;
    sb = b ^ 32'h8000_0000;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a + ~b + 32'd1;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return (sb < sa) ? b : a;
      4'd11:   return (sb > sa) ? b : a;
      4'd12:   return (b < a) ? b : a;
      4'd13:   return (b > a) ? b : a;
      default: return 32'h000E_2202;
    endcase
  endfunction

  function automatic exp_t ref_beat(input logic [3:0] op, input logic [NL-1:0] mask,
                                    input logic [TW-1:0] tag, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    exp_t e;
    e.mask    = mask;
    e.tag     = tag;
    e.illegal = (op > 4'd13);
    e.result  = '0;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) e.result[i*32 +: 32] = ref_lane(op, a[i*32 +: 32], b[i*32 +: 32]);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes visible now, then move to the next falling edge.
  task automatic cyc();
    exp_t e;
    #1;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        outs_seen++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", DW'(out_tag), DW'(4'hx));
        end else begin
          e = sb_q.pop_front();
          check("sb_result", out_result, e.result);
          check("sb_mask", DW'(out_mask), DW'(e.mask));
          check("sb_tag", DW'(out_tag), DW'(e.tag));
          check("sb_illegal", DW'(out_illegal), DW'(e.illegal));
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(ref_beat(in_op, in_mask, in_tag, in_a, in_b));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a single beat into an idle pipe and check it appears exactly PD cycles later.
  task automatic directed(input string name, input logic [3:0] op, input logic [NL-1:0] mask,
                          input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_res, input logic exp_ill);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = alu_op_t'(op);
    in_mask   = mask;
    in_tag    = tag;
    in_a      = a;
    in_b      = b;
    cyc();
    in_valid = 1'b0;
    #1;
    check({name, "_not_early"}, DW'(out_valid), DW'(1'b0));
    cyc();
    #1;
    check({name, "_valid"}, DW'(out_valid), DW'(1'b1));
    check({name, "_result"}, out_result, exp_res);
    check({name, "_mask"}, DW'(out_mask), DW'(mask));
    check({name, "_tag"}, DW'(out_tag), DW'(tag));
    check({name, "_illegal"}, DW'(out_illegal), DW'(exp_ill));
    cyc();
  endtask

  initial begin
    logic acc;
    logic pending;
    int   idx;
    logic [31:0] all_ones;
    all_ones = 32'hFFFF_FFFF;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = ALU_ADD;
    in_mask = '0; in_tag = '0; in_a = '0; in_b = '0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_out_mask", DW'(out_mask), '0);
    check("rst_out_tag", DW'(out_tag), '0);
    check("rst_out_result", out_result, '0);
    check("rst_out_illegal", DW'(out_illegal), DW'(1'b0));
    check("rst_in_ready", DW'(in_ready), DW'(1'b1));

    directed("t1_add", 4'd0, 4'hF, 4'd1,
             pack4(32'h1, all_ones, 32'h7FFF_FFFF, 32'h5),
             pack4(32'h1, 32'h1, 32'h1, 32'hFFFF_FFFB),
             pack4(32'h2, 32'h0, 32'h8000_0000, 32'h0), 1'b0);

    directed("t2_sra", 4'd7, 4'hF, 4'd2, {4{32'h8000_0000}}, {4{32'd31}}, {4{all_ones}}, 1'b0);
    directed("t2_srl", 4'd6, 4'hF, 4'd3, {4{32'h8000_0000}}, {4{32'd31}}, {4{32'h1}}, 1'b0);
    directed("t2_slt", 4'd8, 4'hF, 4'd4, {4{all_ones}}, {4{32'h1}}, {4{32'h1}}, 1'b0);
    directed("t2_sltu", 4'd9, 4'hF, 4'd5, {4{all_ones}}, {4{32'h1}}, {4{32'h0}}, 1'b0);
    directed("t2_min", 4'd10, 4'hF, 4'd6, {4{all_ones}}, {4{32'h1}}, {4{all_ones}}, 1'b0);
    directed("t2_maxu", 4'd13, 4'hF, 4'd7, {4{all_ones}}, {4{32'h1}}, {4{all_ones}}, 1'b0);

    directed("t3_xor", 4'd4, 4'b0101, 4'd8, {4{32'hF0F0_F0F0}}, {4{32'hF0F0_F0F0}}, '0, 1'b0);
    directed("t3_or", 4'd3, 4'b0101, 4'd8, {4{32'hF0F0_F0F0}}, {4{32'hF0F0_F0F0}},
             pack4(32'hF0F0_F0F0, 32'h0, 32'hF0F0_F0F0, 32'h0), 1'b0);
    directed("t3_mask0", 4'd0, 4'b0000, 4'd10, {4{32'h1234_5678}}, {4{32'h1}}, '0, 1'b0);

    directed("t4_illegal", 4'd14, 4'hF, 4'd9, {4{32'h1111_1111}}, {4{32'h2222_2222}},
             {4{32'h000E_2202}}, 1'b1);

    // Six beats against a consumer that stalls for four cycles.
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 4);
      in_valid  = (idx < 6);
      in_op     = ALU_ADD;
      in_mask   = 4'hF;
      in_tag    = idx[TW-1:0];
      in_a      = {4{32'(idx * 3)}};
      in_b      = {4{32'(idx + 100)}};
      #1;
      if (c == 1) check("t5_in_ready_second", DW'(in_ready), DW'(1'b1));
      if (c == 2 || c == 3) check("t5_in_ready_held", DW'(in_ready), DW'(1'b0));
      if (c == 4) outs_seen = 0;
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
      if (c == 9) check("t5_one_per_cycle", DW'(outs_seen), DW'(6));
    end
    in_valid = 1'b0;
    check("t5_all_issued", DW'(idx), DW'(6));
    check("t5_no_loss", DW'(sb_q.size()), '0);

    // Reset with two beats parked in the pipe.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = ALU_XOR;
    in_mask   = 4'hF;
    for (int c = 0; c < 2; c++) begin
      in_tag = TW'(c + 12);
      in_a   = {4{32'(c + 1)}};
      cyc();
    end
    in_valid = 1'b0;
    #1;
    check("t6_full_before_rst", DW'(in_ready), DW'(1'b0));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_out_valid_after_rst", DW'(out_valid), DW'(1'b0));
    check("t6_in_ready_after_rst", DW'(in_ready), DW'(1'b1));
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t6_no_stale", DW'(out_valid), DW'(1'b0));
      cyc();
    end

    // Randomized traffic with random backpressure and a stable-while-pending producer.
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = alu_op_t'($urandom_range(0, 15));
        in_mask  = NL'($urandom);
        in_tag   = TW'($urandom);
        for (int i = 0; i < NL; i++) in_a[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          in_b = in_a;
        end else begin
          for (int i = 0; i < NL; i++) in_b[i*32 +: 32] = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc     = in_valid && in_ready;
      pending = in_valid && !acc;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cyc();
    check("rand_drain_empty", DW'(sb_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
